// File: rtl/out_of_order_wrf_channel.sv
// Reordering CCI-P write channel: slots drain in LFSR-chosen order,
// fences split traffic into epochs that never overlap.
package out_of_order_wrf_channel_pkg;
  localparam int CCIP_DATA_WIDTH = 512;

  localparam logic [1:0] VC_VA  = 2'd0;
  localparam logic [1:0] VC_VL0 = 2'd1;

  localparam logic [1:0] ASE_1CL = 2'd0;
  localparam logic [1:0] ASE_2CL = 2'd1;
  localparam logic [1:0] ASE_4CL = 2'd3;

  localparam logic [3:0] ASE_WRLINE_I = 4'h1;
  localparam logic [3:0] ASE_WRLINE_M = 4'h2;
  localparam logic [3:0] ASE_WRFENCE  = 4'h4;

  localparam logic [3:0] ASE_WR_RSP      = 4'h1;
  localparam logic [3:0] ASE_WRFENCE_RSP = 4'h4;

  typedef struct packed {
    logic [1:0]  vc;
    logic        sop;
    logic        rsvd0;
    logic [1:0]  len;
    logic [3:0]  reqtype;
    logic [5:0]  rsvd1;
    logic [41:0] addr;
    logic [15:0] mdata;
  } TxHdr_t;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        rsvd0;
    logic        hit_miss;
    logic        format;
    logic        rsvd1;
    logic [1:0]  clnum;
    logic [3:0]  resptype;
    logic [15:0] mdata;
  } RxHdr_t;
endpackage

module out_of_order_wrf_channel
  import out_of_order_wrf_channel_pkg::*;
#(
  parameter int UNROLL_ENABLE = 1,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  TxHdr_t                     hdr_in,
  input  logic [CCIP_DATA_WIDTH-1:0] data_in,
  input  logic                       write_en,
  output TxHdr_t                     txhdr_out,
  output RxHdr_t                     rxhdr_out,
  output logic [CCIP_DATA_WIDTH-1:0] data_out,
  output logic                       valid_out,
  input  logic                       read_en,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0]           used;
  TxHdr_t                     hdr_q  [DEPTH];
  logic [CCIP_DATA_WIDTH-1:0] data_q [DEPTH];
  logic [7:0]                 ep_q   [DEPTH];
  logic [1:0]                 beat_q [DEPTH];

  logic [7:0]    in_ep;
  logic [7:0]    out_ep;
  logic [15:0]   lfsr;
  logic          locked;
  logic [AW-1:0] lock_idx;

  logic [AW:0]      cnt;
  logic [DEPTH-1:0] elig;
  logic             cur_wr;
  logic [AW-1:0]    sel;
  logic             found;
  logic [AW-1:0]    free_idx;
  logic             type_ok;
  logic             wr_ok;
  logic             do_pop;

  TxHdr_t                     sh;
  logic [1:0]                 k;
  logic                       fence;
  logic                       last;
  TxHdr_t                     tx_n;
  RxHdr_t                     rx_n;
  logic [CCIP_DATA_WIDTH-1:0] d_n;

  always_comb begin
    cnt = '0;
    cur_wr = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + (AW+1)'(used[i]);
      if (used[i] && ep_q[i] == out_ep &&
          hdr_q[i].reqtype != ASE_WRFENCE)
        cur_wr = 1'b1;
    end
    // a fence waits until no write of its epoch remains
    for (int i = 0; i < DEPTH; i++)
      elig[i] = used[i] && ep_q[i] == out_ep &&
                (hdr_q[i].reqtype != ASE_WRFENCE || !cur_wr);
  end

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);

  always_comb begin
    sel = lock_idx;
    found = 1'b0;
    if (locked) begin
      found = elig[lock_idx];
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!found && elig[lfsr[AW-1:0] + AW'(i)]) begin
          sel = lfsr[AW-1:0] + AW'(i);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!used[i]) free_idx = AW'(i);
  end

  assign type_ok = (hdr_in.reqtype == ASE_WRLINE_I ||
                    hdr_in.reqtype == ASE_WRLINE_M ||
                    hdr_in.reqtype == ASE_WRFENCE) &&
                   hdr_in.len != 2'b10;
  assign wr_ok  = write_en && !full && type_ok;
  assign do_pop = read_en && found;

  always_comb begin
    sh    = hdr_q[sel];
    k     = beat_q[sel];
    fence = (sh.reqtype == ASE_WRFENCE);
    last  = fence || UNROLL_ENABLE == 0 || k == sh.len;
    tx_n  = sh;
    rx_n  = '0;
    rx_n.mdata    = sh.mdata;
    rx_n.vc_used  = (sh.vc == VC_VA) ? VC_VL0 : sh.vc;
    rx_n.resptype = fence ? ASE_WRFENCE_RSP : ASE_WR_RSP;
    d_n = fence ? '0 : data_q[sel];
    if (!fence) begin
      if (UNROLL_ENABLE != 0) begin
        tx_n.addr  = sh.addr + 42'(k);
        tx_n.len   = ASE_1CL;
        tx_n.sop   = (k == 2'd0);
        rx_n.clnum = k;
      end else begin
        rx_n.format = 1'b1;
        rx_n.clnum  = sh.len;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      used      <= '0;
      in_ep     <= '0;
      out_ep    <= '0;
      lfsr      <= 16'hACE1;
      locked    <= 1'b0;
      lock_idx  <= '0;
      valid_out <= 1'b0;
      txhdr_out <= '0;
      rxhdr_out <= '0;
      data_out  <= '0;
    end else begin
      valid_out <= do_pop;
      if (wr_ok) begin
        used[free_idx]   <= 1'b1;
        hdr_q[free_idx]  <= hdr_in;
        data_q[free_idx] <= data_in;
        ep_q[free_idx]   <= in_ep;
        beat_q[free_idx] <= 2'd0;
        if (hdr_in.reqtype == ASE_WRFENCE)
          in_ep <= in_ep + 8'd1;
      end
      if (do_pop) begin
        lfsr <= {lfsr[14:0],
                 lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        txhdr_out <= tx_n;
        rxhdr_out <= rx_n;
        data_out  <= d_n;
        if (last) begin
          used[sel] <= 1'b0;
          locked    <= 1'b0;
          if (fence) out_ep <= out_ep + 8'd1;
        end else begin
          beat_q[sel] <= k + 2'd1;
          locked      <= 1'b1;
          lock_idx    <= sel;
        end
      end
    end
  end
endmodule

// File: tb/tb_out_of_order_wrf_channel.sv
// Scoreboard bench for the reordering write channel; the monitor matches
// each beat against outstanding expectations and checks epoch order.
module tb_out_of_order_wrf_channel;
  import out_of_order_wrf_channel_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  TxHdr_t hdr1, hdr0, tx1, tx0;
  RxHdr_t rx1, rx0;
  logic [511:0] data1, data0, do1, do0;
  logic we1, re1, v1, e1, f1;
  logic we0, re0, v0, e0, f0;

  out_of_order_wrf_channel #(.UNROLL_ENABLE(1), .DEPTH(16)) u1 (
    .clk(clk), .rst(rst), .hdr_in(hdr1), .data_in(data1),
    .write_en(we1), .txhdr_out(tx1), .rxhdr_out(rx1),
    .data_out(do1), .valid_out(v1), .read_en(re1),
    .empty(e1), .full(f1));

  out_of_order_wrf_channel #(.UNROLL_ENABLE(0), .DEPTH(16)) u0 (
    .clk(clk), .rst(rst), .hdr_in(hdr0), .data_in(data0),
    .write_en(we0), .txhdr_out(tx0), .rxhdr_out(rx0),
    .data_out(do0), .valid_out(v0), .read_en(re0),
    .empty(e0), .full(f0));

  typedef struct {
    logic [15:0]  md;
    logic [41:0]  addr;
    logic [1:0]   k;
    bit           last;
    bit           fence;
    logic [7:0]   ep;
    logic [1:0]   vc;
    logic [511:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] log_q[$];
  int total = 0;
  int bad = 0;
  int beats = 0;
  int exp_lines = 0;
  logic [7:0]  in_ep_m = 8'd0;
  logic [7:0]  out_ep_m = 8'd0;
  bit          pend = 1'b0;
  logic [15:0] lock_md = 16'd0;
  logic [1:0]  lock_k = 2'd0;

  function automatic logic [511:0] mk_data(input logic [15:0] md);
    return {16{md, 16'hC0DE}};
  endfunction

  task automatic push1(input logic [3:0] rt, input logic [1:0] len,
                       input logic [41:0] addr, input logic [1:0] vc,
                       input logic [15:0] md, output bit acc);
    TxHdr_t h;
    exp_t e;
    h = '0;
    h.vc = vc; h.sop = 1'b1; h.len = len; h.reqtype = rt;
    h.addr = addr; h.mdata = md;
    hdr1 = h;
    data1 = mk_data(md);
    we1 = 1'b1;
    acc = !f1 && (rt == 4'h1 || rt == 4'h2 || rt == 4'h4) && len != 2'b10;
    if (acc) begin
      e.md = md; e.vc = vc; e.ep = in_ep_m; e.data = mk_data(md);
      if (rt == 4'h4) begin
        e.addr = addr; e.k = 2'd0; e.last = 1'b1; e.fence = 1'b1;
        exp_q.push_back(e);
        exp_lines++;
        in_ep_m++;
      end else begin
        for (int i = 0; i <= int'(len); i++) begin
          e.addr = addr + 42'(i); e.k = 2'(i);
          e.last = (i == int'(len)); e.fence = 1'b0;
          exp_q.push_back(e);
          exp_lines++;
        end
      end
    end
    @(negedge clk);
    we1 = 1'b0;
  endtask

  task automatic wait_empty(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    int hit;
    bit other;
    exp_t e;
    logic [3:0] rt;
    logic [1:0] vcx;
    if (!rst && v1) begin
      beats++;
      log_q.push_back(rx1.mdata);
      hit = -1;
      foreach (exp_q[i])
        if (hit < 0 && exp_q[i].md == rx1.mdata && exp_q[i].k == rx1.clnum)
          hit = i;
      total++;
      if (hit < 0) begin
        bad++;
        $display("FAIL unexpected_beat: mdata=%h clnum=%0d has no outstanding match",
                 rx1.mdata, rx1.clnum);
      end else begin
        e = exp_q[hit];
        exp_q.delete(hit);
        total++;
        if (e.ep !== out_ep_m) begin
          bad++;
          $display("FAIL fence_cross: mdata=%h epoch=%0d required %0d",
                   e.md, e.ep, out_ep_m);
        end
        if (pend) begin
          total++;
          if (rx1.mdata !== lock_md || rx1.clnum !== lock_k) begin
            bad++;
            $display("FAIL interleave: got mdata=%h k=%0d required mdata=%h k=%0d",
                     rx1.mdata, rx1.clnum, lock_md, lock_k);
          end
        end
        pend = 1'b0;
        rt = e.fence ? 4'h4 : 4'h1;
        vcx = (e.vc == 2'd0) ? 2'd1 : e.vc;
        total++;
        if (rx1.resptype !== rt || rx1.vc_used !== vcx || rx1.hit_miss !== 1'b0) begin
          bad++;
          $display("FAIL rx_fields: resptype=%h vc=%0d hm=%b required %h %0d 0",
                   rx1.resptype, rx1.vc_used, rx1.hit_miss, rt, vcx);
        end
        if (e.fence) begin
          other = 1'b0;
          foreach (exp_q[i]) if (exp_q[i].ep == e.ep) other = 1'b1;
          total++;
          if (other || do1 !== '0) begin
            bad++;
            $display("FAIL fence_emit: early=%b data_nonzero=%b required 0 0",
                     other, do1 !== '0);
          end
          out_ep_m++;
        end else begin
          total++;
          if (tx1.addr !== e.addr || tx1.sop !== (e.k == 2'd0) ||
              tx1.len !== 2'd0 || rx1.format !== 1'b0 || do1 !== e.data) begin
            bad++;
            $display("FAIL beat_hdr: addr=%h sop=%b len=%0d fmt=%b required addr=%h sop=%b len=0 fmt=0",
                     tx1.addr, tx1.sop, tx1.len, rx1.format, e.addr, e.k == 2'd0);
          end
          if (!e.last) begin
            pend = 1'b1;
            lock_md = e.md;
            lock_k = e.k + 2'd1;
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (v1 !== 1'b0 || e1 !== 1'b1 || f1 !== 1'b0 || e0 !== 1'b1 || v0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: v=%b empty=%b full=%b required 0 1 0", v1, e1, f1);
    end
    total++;
    if (tx1 !== '0 || rx1 !== '0 || do1 !== '0) begin
      bad++;
      $display("FAIL reset_outputs: tx=%h rx=%h required 0", tx1, rx1);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int b0;
    bit acc, ok;
    b0 = beats;
    log_q.delete();
    re1 = 1'b1;
    for (int i = 0; i < 4; i++)
      push1(4'h1, 2'd0, 42'h8400_0000 + 42'(i), 2'd0, 16'(i), acc);
    wait_empty(200, ok);
    total++;
    if (!ok || beats - b0 !== 4) begin
      bad++;
      $display("FAIL basic_count: beats=%0d required 4 drained=%b", beats - b0, ok);
    end
    total++;
    if (e1 !== 1'b1) begin
      bad++;
      $display("FAIL basic_empty: empty=%b required 1", e1);
    end
  endtask

  task automatic test_fence();
    bit acc, ok;
    logic [15:0] a, b;
    log_q.delete();
    re1 = 1'b1;
    push1(4'h1, 2'd0, 42'h100, 2'd1, 16'd0, acc);
    push1(4'h2, 2'd0, 42'h101, 2'd2, 16'd1, acc);
    push1(4'h4, 2'd0, 42'h0, 2'd0, 16'd2, acc);
    push1(4'h1, 2'd0, 42'h103, 2'd3, 16'd3, acc);
    push1(4'h1, 2'd0, 42'h104, 2'd0, 16'd4, acc);
    wait_empty(200, ok);
    total++;
    if (!ok || log_q.size() != 5) begin
      bad++;
      $display("FAIL fence_count: beats=%0d required 5", log_q.size());
    end else begin
      a = log_q[0]; b = log_q[1];
      total++;
      if (log_q[2] !== 16'd2 || !((a == 0 && b == 1) || (a == 1 && b == 0))) begin
        bad++;
        $display("FAIL fence_order: seq=%0d %0d %0d required {0,1} then 2",
                 a, b, log_q[2]);
      end
      a = log_q[3]; b = log_q[4];
      total++;
      if (!((a == 3 && b == 4) || (a == 4 && b == 3))) begin
        bad++;
        $display("FAIL fence_after: seq=%0d %0d required {3,4}", a, b);
      end
    end
  endtask

  task automatic test_unroll();
    bit acc, ok, seen;
    int n;
    TxHdr_t h;
    log_q.delete();
    re1 = 1'b1;
    push1(4'h1, 2'd3, 42'h2_0000_0010, 2'd2, 16'd7, acc);
    wait_empty(200, ok);
    total++;
    if (!ok || log_q.size() != 4) begin
      bad++;
      $display("FAIL unroll_count: beats=%0d required 4", log_q.size());
    end
    h = '0;
    h.vc = 2'd0; h.sop = 1'b1; h.len = 2'd3; h.reqtype = 4'h1;
    h.addr = 42'h2_0000_0010; h.mdata = 16'd7;
    hdr0 = h; data0 = mk_data(16'd7); we0 = 1'b1; re0 = 1'b1;
    @(negedge clk);
    we0 = 1'b0;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (v0) begin
        n++;
        if (!seen) begin
          seen = 1'b1;
          total++;
          if (tx0 !== h || rx0.format !== 1'b1 || rx0.clnum !== 2'b11 ||
              rx0.mdata !== 16'd7 || rx0.resptype !== 4'h1 ||
              rx0.vc_used !== 2'd1 || do0 !== mk_data(16'd7)) begin
            bad++;
            $display("FAIL nounroll_beat: tx=%h fmt=%b cl=%0d md=%h required tx=%h fmt=1 cl=3 md=7",
                     tx0, rx0.format, rx0.clnum, rx0.mdata, h);
          end
        end
      end
      @(negedge clk);
    end
    total++;
    if (n != 1 || e0 !== 1'b1) begin
      bad++;
      $display("FAIL nounroll_count: beats=%0d empty=%b required 1 1", n, e0);
    end
    re0 = 1'b0;
  endtask

  task automatic test_full();
    bit acc, ok;
    int b0;
    re1 = 1'b0;
    push1(4'h0, 2'd0, 42'h5, 2'd0, 16'h0EE0, acc);
    push1(4'h1, 2'b10, 42'h6, 2'd0, 16'h0EE1, acc);
    repeat (2) @(negedge clk);
    total++;
    if (e1 !== 1'b1) begin
      bad++;
      $display("FAIL drop_invalid: empty=%b required 1", e1);
    end
    for (int i = 0; i < 16; i++)
      push1(4'h2, 2'd0, 42'h300 + 42'(i), 2'd1, 16'h0100 + 16'(i), acc);
    total++;
    if (f1 !== 1'b1 || e1 !== 1'b0) begin
      bad++;
      $display("FAIL fill_flags: full=%b empty=%b required 1 0", f1, e1);
    end
    b0 = beats;
    re1 = 1'b1;
    push1(4'h1, 2'd0, 42'h400, 2'd1, 16'h0DDD, acc);
    total++;
    if (acc) begin
      bad++;
      $display("FAIL full_push: model accepted push while full=%b", f1);
    end
    wait_empty(300, ok);
    total++;
    if (!ok || beats - b0 !== 16 || e1 !== 1'b1) begin
      bad++;
      $display("FAIL drain_full: beats=%0d empty=%b required 16 1", beats - b0, e1);
    end
  endtask

  task automatic test_midreset();
    bit acc;
    int b0;
    re1 = 1'b0;
    for (int i = 0; i < 5; i++)
      push1(4'h1, 2'd1, 42'h500 + 42'(2 * i), 2'd0, 16'h0200 + 16'(i), acc);
    rst = 1'b1;
    exp_q.delete();
    in_ep_m = 8'd0;
    out_ep_m = 8'd0;
    pend = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (e1 !== 1'b1 || v1 !== 1'b0 || f1 !== 1'b0) begin
      bad++;
      $display("FAIL midreset_flags: empty=%b valid=%b required 1 0", e1, v1);
    end
    b0 = beats;
    re1 = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if (beats != b0) begin
      bad++;
      $display("FAIL midreset_stale: beats=%0d required 0", beats - b0);
    end
  endtask

  task automatic test_stress();
    bit acc, ok;
    int b0, l0, guard;
    logic [15:0] md;
    logic [3:0] rt;
    logic [1:0] len;
    logic [1:0] lens [3];
    lens[0] = 2'd0; lens[1] = 2'd1; lens[2] = 2'd3;
    b0 = beats;
    l0 = exp_lines;
    md = 16'h1000;
    guard = 0;
    re1 = 1'b1;
    for (int n = 0; n < 4096 && guard < 60000; n++) begin
      if ($urandom_range(6) == 0) rt = 4'h4;
      else rt = $urandom_range(1) ? 4'h1 : 4'h2;
      len = lens[$urandom_range(2)];
      acc = 1'b0;
      while (!acc && guard < 60000) begin
        push1(rt, len, {10'd0, 32'($urandom)}, 2'($urandom), md, acc);
        guard++;
      end
      md++;
    end
    total++;
    if (guard >= 60000) begin
      bad++;
      $display("FAIL stress_stall: pushes blocked, guard=%0d", guard);
    end
    wait_empty(20000, ok);
    total++;
    if (!ok || exp_q.size() != 0) begin
      bad++;
      $display("FAIL stress_missing: outstanding=%0d required 0", exp_q.size());
    end
    total++;
    if (beats - b0 !== exp_lines - l0) begin
      bad++;
      $display("FAIL stress_beats: beats=%0d required %0d", beats - b0, exp_lines - l0);
    end
  endtask

  initial begin
    hdr1 = '0; data1 = '0; we1 = 1'b0; re1 = 1'b0;
    hdr0 = '0; data0 = '0; we0 = 1'b0; re0 = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_fence();
    test_unroll();
    test_full();
    test_midreset();
    test_stress();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end
endmodule
